// File: rtl/ker_sram_pkg.sv
// Shared kernel-SRAM definitions: word/address widths, bank count and the
// reader FSM state encoding. Used by both the kernel reader and writer.
package ker_sram_pkg;

    localparam int KER_DATA_W = 64;
    localparam int KER_ADDR_W = 11;
    localparam int KER_BANKS  = 8;
    localparam int KER_WCNT_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ker_state_t;

endpackage

// File: rtl/ker_rd_skid.sv
// Two-entry output buffer between the SRAM read port and the stream.
// A word arriving while the buffer is empty and the stream is ready flows
// straight through. Otherwise it is stored in arrival order.
module ker_rd_skid #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic              pop;
    logic              stor_pop;
    logic              stor_push;

    // Present the oldest word: stored head first, otherwise the arriving word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        out_data  = '0;
        out_valid = (count != 2'd0) || in_valid;
        if (count != 2'd0) begin
            out_data = slot0;
        end else if (in_valid) begin
            out_data = in_data;
        end
        pop       = out_valid && ready;
        stor_pop  = pop && (count != 2'd0);
        stor_push = in_valid && !(pop && (count == 2'd0));
    end

    // Occupancy tracking; emptied on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, stor_push} - {1'b0, stor_pop};
        end
    end

    // Storage shift/fill.
    // NOTE: the data slots are not reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (stor_pop) begin
            slot0 <= (count == 2'd2) ? slot1 : in_data;
            slot1 <= in_data;
        end else if (stor_push) begin
            if (count == 2'd0) begin
                slot0 <= in_data;
            end else begin
                slot1 <= in_data;
            end
        end
    end

endmodule

// File: rtl/ker_sram_r.sv
// Kernel SRAM reader. It streams ker_read_len+1 words from each of the 8 banks
// in address-major, bank-minor order into a downstream FIFO. Reads are issued
// only while the 2-entry output buffer can absorb them, so no word is dropped
// under backpressure.
// Optional: define KER_SRAM_R_WCNT_EN to add the ker_read_wcnt_dout word counter.
module ker_sram_r
    import ker_sram_pkg::*;
#(
    parameter int DATA_W = KER_DATA_W,
    parameter int ADDR_W = KER_ADDR_W,
    parameter int BANKS  = KER_BANKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_ker_read,
    input  logic [ADDR_W-1:0] ker_read_len,
    output logic              ker_read_busy,
    output logic              ker_read_done,
    output logic [DATA_W-1:0] ker_read_data_dout,
    input  logic              ker_read_full_n_din,
    output logic              ker_read_write_dout,
    output logic              cen_kersr_0, cen_kersr_1, cen_kersr_2, cen_kersr_3,
    output logic              cen_kersr_4, cen_kersr_5, cen_kersr_6, cen_kersr_7,
    output logic              wen_kersr_0, wen_kersr_1, wen_kersr_2, wen_kersr_3,
    output logic              wen_kersr_4, wen_kersr_5, wen_kersr_6, wen_kersr_7,
    output logic [ADDR_W-1:0] addr__kersr_0, addr__kersr_1, addr__kersr_2, addr__kersr_3,
    output logic [ADDR_W-1:0] addr__kersr_4, addr__kersr_5, addr__kersr_6, addr__kersr_7,
    input  logic [DATA_W-1:0] dout_kersr_0, dout_kersr_1, dout_kersr_2, dout_kersr_3,
    input  logic [DATA_W-1:0] dout_kersr_4, dout_kersr_5, dout_kersr_6, dout_kersr_7
`ifdef KER_SRAM_R_WCNT_EN
    ,
    output logic [KER_WCNT_W-1:0] ker_read_wcnt_dout
`endif
);

    localparam int BANK_W = $clog2(BANKS);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BANKS - 1);

    ker_state_t        state;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len_q;
    logic [BANK_W-1:0] bank;
    logic [BANK_W-1:0] rd_bank;
    logic              rd_vld;
    logic              issue;
    logic              last_issue;
    logic              drain_empty;
    logic              pop;
    logic              buf_valid;
    logic [1:0]        buf_count;
    logic [2:0]        occ;
    logic [BANKS-1:0]  cen;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] bank_dout [BANKS];

    assign bank_dout[0] = dout_kersr_0;
    assign bank_dout[1] = dout_kersr_1;
    assign bank_dout[2] = dout_kersr_2;
    assign bank_dout[3] = dout_kersr_3;
    assign bank_dout[4] = dout_kersr_4;
    assign bank_dout[5] = dout_kersr_5;
    assign bank_dout[6] = dout_kersr_6;
    assign bank_dout[7] = dout_kersr_7;
    assign rd_data      = bank_dout[rd_bank];

    ker_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_vld),
        .in_data   (rd_data),
        .ready     (ker_read_full_n_din),
        .out_valid (buf_valid),
        .out_data  (ker_read_data_dout),
        .count     (buf_count)
    );

    assign pop                 = buf_valid && ker_read_full_n_din;
    assign ker_read_write_dout = pop;

    // Credit check: buffered + in-flight - popped must leave room for one more read.
    always_comb begin
        cen         = '1;
        occ         = {1'b0, buf_count} + {2'b00, rd_vld};
        issue       = (state == ST_READ) && (occ < (3'd2 + {2'b00, pop}));
        last_issue  = issue && (bank == LAST_BANK) && (addr == len_q);
        drain_empty = (occ == {2'b00, pop});
        if (issue) begin
            cen[bank] = 1'b0;
        end
    end

    // Job FSM with address/bank counters and registered busy/done.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            addr    <= '0;
            len_q   <= '0;
            bank    <= '0;
            rd_bank <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld  <= issue;
            rd_bank <= bank;
            done    <= 1'b0;
            if (issue) begin
                if (bank == LAST_BANK) begin
                    bank <= '0;
                    if (addr != len_q) begin
                        addr <= addr + 1'b1;
                    end
                end else begin
                    bank <= bank + 1'b1;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start_ker_read) begin
                        state <= ST_READ;
                        busy  <= 1'b1;
                        len_q <= ker_read_len;
                        addr  <= '0;
                        bank  <= '0;
                    end
                end
                ST_READ: begin
                    if (last_issue) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef KER_SRAM_R_WCNT_EN
    logic [KER_WCNT_W-1:0] wcnt;

    // Words written in the current job; cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt <= '0;
        end else if ((state == ST_IDLE) && start_ker_read) begin
            wcnt <= '0;
        end else if (pop) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign ker_read_wcnt_dout = wcnt;
`endif

    assign ker_read_busy = busy;
    assign ker_read_done = done;

    assign cen_kersr_0 = cen[0];
    assign cen_kersr_1 = cen[1];
    assign cen_kersr_2 = cen[2];
    assign cen_kersr_3 = cen[3];
    assign cen_kersr_4 = cen[4];
    assign cen_kersr_5 = cen[5];
    assign cen_kersr_6 = cen[6];
    assign cen_kersr_7 = cen[7];

    assign wen_kersr_0 = 1'b1;
    assign wen_kersr_1 = 1'b1;
    assign wen_kersr_2 = 1'b1;
    assign wen_kersr_3 = 1'b1;
    assign wen_kersr_4 = 1'b1;
    assign wen_kersr_5 = 1'b1;
    assign wen_kersr_6 = 1'b1;
    assign wen_kersr_7 = 1'b1;

    assign addr__kersr_0 = addr;
    assign addr__kersr_1 = addr;
    assign addr__kersr_2 = addr;
    assign addr__kersr_3 = addr;
    assign addr__kersr_4 = addr;
    assign addr__kersr_5 = addr;
    assign addr__kersr_6 = addr;
    assign addr__kersr_7 = addr;

endmodule

// File: tb/tb_ker_sram_r.sv
// Bench for ker_sram_r: SRAM bank models preloaded with a {bank,addr} pattern,
// expected words queued at job start, and a monitor that pops and compares on
// every stream write.
module tb_ker_sram_r;
    import ker_sram_pkg::*;

    localparam int DW = KER_DATA_W;
    localparam int AW = KER_ADDR_W;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] len = '0;
    logic          full_n = 1'b1;
    logic          busy, done, wr;
    logic [DW-1:0] data;
    wire  [NB-1:0] cen;
    wire  [NB-1:0] wen;
    wire  [AW-1:0] addr [NB];
    logic [DW-1:0] dout [NB];
`ifdef KER_SRAM_R_WCNT_EN
    logic [KER_WCNT_W-1:0] wcnt;
`endif

    ker_sram_r dut (
        .clk(clk), .reset(reset), .start_ker_read(start), .ker_read_len(len),
        .ker_read_busy(busy), .ker_read_done(done), .ker_read_data_dout(data),
        .ker_read_full_n_din(full_n), .ker_read_write_dout(wr),
        .cen_kersr_0(cen[0]), .cen_kersr_1(cen[1]), .cen_kersr_2(cen[2]), .cen_kersr_3(cen[3]),
        .cen_kersr_4(cen[4]), .cen_kersr_5(cen[5]), .cen_kersr_6(cen[6]), .cen_kersr_7(cen[7]),
        .wen_kersr_0(wen[0]), .wen_kersr_1(wen[1]), .wen_kersr_2(wen[2]), .wen_kersr_3(wen[3]),
        .wen_kersr_4(wen[4]), .wen_kersr_5(wen[5]), .wen_kersr_6(wen[6]), .wen_kersr_7(wen[7]),
        .addr__kersr_0(addr[0]), .addr__kersr_1(addr[1]), .addr__kersr_2(addr[2]), .addr__kersr_3(addr[3]),
        .addr__kersr_4(addr[4]), .addr__kersr_5(addr[5]), .addr__kersr_6(addr[6]), .addr__kersr_7(addr[7]),
        .dout_kersr_0(dout[0]), .dout_kersr_1(dout[1]), .dout_kersr_2(dout[2]), .dout_kersr_3(dout[3]),
        .dout_kersr_4(dout[4]), .dout_kersr_5(dout[5]), .dout_kersr_6(dout[6]), .dout_kersr_7(dout[7])
`ifdef KER_SRAM_R_WCNT_EN
        , .ker_read_wcnt_dout(wcnt)
`endif
    );

    always #5 clk = ~clk;

    // Preloaded bank contents: bank b, address a holds {tag, b, a}.
    function automatic logic [DW-1:0] pat(input int b, input int a);
        return {16'hC0DE, 16'(b), 32'(a)};
    endfunction

    // Synchronous-read SRAM banks: data valid the cycle after CEN=0.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (cen[b] == 1'b0) dout[b] <= pat(b, int'(addr[b]));
        end
    end

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [DW-1:0] exp_q [$];
    int            cyc = 0;
    int            start_cyc = 0;
    int            last_wr_cyc = 0;
    int            job_words = 0;
    int            issued = 0;
    int            written = 0;
    bit            job_active = 0;
    bit            done_seen = 0;
    bit            chk_lat = 0;
    int            fmode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Downstream FIFO model: always ready, random 50%, or held full.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (fmode)
                0:       full_n = 1'b1;
                1:       full_n = 1'($urandom_range(0, 1));
                default: full_n = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pop/compare, CEN rules, outstanding-read bound, done timing.
    always @(negedge clk) begin
        int low;
        logic [DW-1:0] e;
        if (reset) begin
            exp_q.delete();
            issued     = 0;
            written    = 0;
            job_active = 0;
        end else begin
            low = 0;
            for (int b = 0; b < NB; b++) if (cen[b] == 1'b0) low++;
            check("wen_high", 64'(wen), 64'hFF);
            if (busy) check("cen_onehot", 64'(low <= 1), 64'd1);
            else      check("cen_idle", 64'(low), 64'd0);
            issued += low;
            if (wr === 1'b1) begin
                written++;
                check("write_needs_full_n", 64'(full_n), 64'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_write: got %h, expected no write (cycle %0d)", data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_word", data, e);
                end
                if (job_words == 0 && chk_lat) check("first_write_latency", 64'(cyc - start_cyc), 64'd2);
                job_words++;
                last_wr_cyc = cyc;
            end
            check("outstanding_le2", 64'((issued - written) <= 2), 64'd1);
            if (done === 1'b1) begin
                check("done_in_job", 64'(job_active), 64'd1);
                check("done_after_last_write", 64'(cyc - last_wr_cyc), 64'd1);
                check("done_queue_empty", 64'(exp_q.size()), 64'd0);
                check("busy_at_done", 64'(busy), 64'd1);
                job_active = 0;
                done_seen  = 1;
            end
        end
    end

    int job_exp = 0;

    task automatic start_job(input int l, input bit lat);
        @(posedge clk);
        #1;
        for (int a = 0; a <= l; a++)
            for (int b = 0; b < NB; b++) exp_q.push_back(pat(b, a));
        job_exp    = (l + 1) * NB;
        job_words  = 0;
        job_active = 1;
        done_seen  = 0;
        chk_lat    = lat;
        len        = AW'(l);
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = AW'($urandom);
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_within_budget", 64'(done_seen), 64'd1);
        @(negedge clk);
        check("busy_clear_after_done", 64'(busy), 64'd0);
        check("job_word_count", 64'(job_words), 64'(job_exp));
`ifdef KER_SRAM_R_WCNT_EN
        check("wcnt_after_done", 64'(wcnt), 64'(job_exp));
`endif
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (job_words < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("words_reached", 64'(job_words >= n), 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_write", 64'(wr), 64'd0);
        check("rst_data", data, 64'd0);
        check("rst_cen", 64'(cen), 64'hFF);
        check("rst_wen", 64'(wen), 64'hFF);
        for (int b = 0; b < NB; b++) check("rst_addr", 64'(addr[b]), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic job, latency and ordering.
        start_job(3, 1);
        wait_done(200);

        // Minimum job.
        start_job(0, 1);
        wait_done(100);

        // Random backpressure.
        fmode = 1;
        start_job(15, 0);
        wait_done(3000);
        fmode = 0;

        // Long stall mid-job.
        start_job(7, 1);
        wait_words(5, 200);
        fmode = 2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_no_write", 64'(wr), 64'd0);
            if (i >= 3) check("stall_cen_idle", 64'(cen), 64'hFF);
        end
        fmode = 0;
        wait_done(500);

        // Reset mid-job, then a clean job.
        start_job(7, 1);
        wait_words(10, 200);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cen", 64'(cen), 64'hFF);
        for (int i = 0; i < 10; i++) begin
            check("midrst_no_done", 64'(done), 64'd0);
            @(negedge clk);
        end
        start_job(7, 1);
        wait_done(500);

        // Start pulses while busy are ignored.
        start_job(7, 1);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        len   = AW'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(500);
`ifdef KER_SRAM_R_WCNT_EN
        repeat (3) @(negedge clk);
        check("wcnt_holds", 64'(wcnt), 64'd64);
`endif

        // Randomised jobs.
        for (int j = 0; j < 4; j++) begin
            fmode = $urandom_range(0, 1);
            start_job($urandom_range(0, 20), 0);
            wait_done(5000);
        end
        fmode = 0;

        // Largest job: address counter must end at 2047 without wrapping.
        start_job(2047, 1);
        wait_done(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ker_sram_r.md
KER_SRAM_R -- requirements
Module: ker_sram_r

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the SRAM and stream word width.
REQ-002 SHALL have parameter ADDR_W, default 11, the per-bank address width.
REQ-003 SHALL have parameter BANKS, default 8, the number of KER SRAM banks (fixed at 8 in this release).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start_ker_read, input, 1 bit: single-cycle start request.
REQ-007 SHALL have port ker_read_len, input, ADDR_W bits: last address to read, so the job reads ker_read_len+1 words per bank; sampled on an accepted start.
REQ-008 SHALL have ports ker_read_busy and ker_read_done, output, 1 bit each: job active, and a one-cycle completion pulse.
REQ-009 SHALL have port ker_read_data_dout, output, DATA_W bits: outgoing stream word.
REQ-010 SHALL have port ker_read_full_n_din, input, 1 bit: downstream FIFO not full.
REQ-011 SHALL have port ker_read_write_dout, output, 1 bit: stream write strobe.
REQ-012 SHALL have ports cen_kersr_0..7, output, 1 bit each: active-low bank chip enable.
REQ-013 SHALL have ports wen_kersr_0..7, output, 1 bit each: active-low write enable, tied to 1 (the block never writes).
REQ-014 SHALL have ports addr__kersr_0..7, output, ADDR_W bits each: bank address.
REQ-015 SHALL have ports dout_kersr_0..7, input, DATA_W bits each: bank read data, valid one cycle after a CEN=0 cycle.

Function
REQ-016 SHALL implement the FSM IDLE -> READ -> DRAIN -> DONE -> IDLE.
REQ-017 SHALL accept start_ker_read only in IDLE, and SHALL ignore it in every other state.
REQ-018 SHALL read in address-major, bank-minor order: (addr0, bank0..7), (addr1, bank0..7), ... up to (len, bank7).
REQ-019 SHALL drive CEN=0 on exactly one bank per issue cycle and CEN=1 on all other banks.
REQ-020 SHALL hold every bank at CEN=1 in every cycle with no issue.
REQ-021 SHALL capture the selected bank's dout on the cycle after issue into a 2-entry output buffer.
REQ-022 SHALL issue a read only when (buffered entries + in-flight reads - pop this cycle) is less than 2, so that no word is ever dropped.
REQ-023 SHALL assert ker_read_write_dout whenever the buffer is non-empty and ker_read_full_n_din=1; each asserted cycle pops one word.
REQ-024 SHALL, with the downstream never full, sustain one word per cycle after a 2-cycle latency (start cycle to first write).
REQ-025 SHALL move from READ to DRAIN after issuing (len, bank7), and from DRAIN to DONE when the buffer is empty and no read is in flight.
REQ-026 SHALL assert ker_read_done for exactly one cycle in DONE.
REQ-027 SHALL hold ker_read_busy high from the cycle after an accepted start through the DONE cycle, inclusive.
REQ-028 SHALL treat len=0 as a valid job of 8 words.
REQ-029 SHALL treat len=2047 as a valid job of 16384 words, with the address counter saturating at the end and no wrap.
REQ-030 SHALL stall issue without limit while ker_read_full_n_din=0, with no loss and no reordering of words.

Reset
REQ-031 SHALL, on reset, set state=IDLE, busy=0, done=0, write=0, and data=0.
REQ-032 SHALL, on reset, set all CEN=1, all WEN=1, all addresses=0, and empty the buffer.
REQ-033 SHALL, on reset mid-job, abandon the job without asserting done.

Configuration
REQ-034 SHALL, with KER_SRAM_R_WCNT_EN defined, add output ker_read_wcnt_dout (15 bits) that counts words written in the current job, clears on an accepted start, and holds after done.
REQ-035 SHALL, without KER_SRAM_R_WCNT_EN, have no such port and no counter logic.

Structure
REQ-036 SHALL take DATA_W, ADDR_W, BANKS and the FSM state encoding from shared package ker_sram_pkg, which is also used by the kernel writer.
REQ-037 SHALL implement the 2-entry output buffer as sub-module ker_rd_skid.

Verification
REQ-038 SHALL verify: preload bank b, address a with {b,a} pattern; len=3, full_n always 1 -> 32 writes in order (a0b0..a3b7); first write 2 cycles after start; done 1 cycle after the last write.
REQ-039 SHALL verify: len=0 -> exactly 8 writes of address 0, banks 0..7, then a done pulse.
REQ-040 SHALL verify: len=15 with full_n toggled at random (50%) -> 128 words in order, none duplicated or lost, and never more than 2 reads outstanding.
REQ-041 SHALL verify: full_n=0 held 20 cycles mid-job -> write=0 and all CEN=1 once the buffer is full, then the stream resumes with the correct next word.
REQ-042 SHALL verify: reset asserted at word 10 of len=7 -> next cycle busy=0, all CEN=1, no done; a new start then runs a full 64-word job.
REQ-043 SHALL verify: start pulsed while busy -> ignored, and the job's word count is unchanged (checked via ker_read_wcnt_dout=64 when KER_SRAM_R_WCNT_EN is defined).
